// File: rtl/shift_reg_mc.sv
// shift_reg_mc -- multi-cycle shift register with load, logical/arithmetic
// shifts and rotates. One one-bit step is taken per enabled clock edge. An
// IDLE/SHIFT FSM counts the remaining steps.
// Optional feature macro: SHIFT_REG_SERIAL_EN adds serial_in/serial_out and
// enables mode 111 (serial shift-left). Without the macro, mode 111 is a hold.
module shift_reg_mc #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic [2:0]         shift_direction,
    input  logic [SHIFT_W-1:0] shift_amount,
    input  logic [WIDTH-1:0]   data_in,
`ifdef SHIFT_REG_SERIAL_EN
    input  logic               serial_in,
    output logic               serial_out,
`endif
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SLL  = 3'b010;
    localparam logic [2:0] MODE_SRL  = 3'b011;
    localparam logic [2:0] MODE_SRA  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_SER  = 3'b111;

    localparam logic [SHIFT_W-1:0] CNT_ZERO = '0;
    localparam logic [SHIFT_W-1:0] CNT_ONE  = {{(SHIFT_W-1){1'b0}}, 1'b1};

`ifdef SHIFT_REG_SERIAL_EN
    localparam bit SERIAL_EN = 1'b1;
`else
    localparam bit SERIAL_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_data;
    logic [2:0]           r_mode;
    logic [SHIFT_W-1:0]   r_count;
    logic                 r_done;

    logic                 w_serial_bit;
    logic                 w_cmd_is_shift;
    logic [WIDTH-1:0]     w_step_cmd;
    logic [WIDTH-1:0]     w_step_run;

`ifdef SHIFT_REG_SERIAL_EN
    assign w_serial_bit = serial_in;
    assign serial_out   = r_data[WIDTH-1];
`else
    assign w_serial_bit = 1'b0;
`endif

    // One single-bit step of the given mode; non-shift modes return d unchanged.
    function automatic logic [WIDTH-1:0] f_step(input logic [2:0] mode,
                                                input logic [WIDTH-1:0] d,
                                                input logic sin);
        logic [WIDTH-1:0] res;
        res = d;
        case (mode)
            MODE_SLL: res = {d[WIDTH-2:0], 1'b0};
            MODE_SRL: res = {1'b0, d[WIDTH-1:1]};
            MODE_SRA: res = {d[WIDTH-1], d[WIDTH-1:1]};
            MODE_ROL: res = {d[WIDTH-2:0], d[WIDTH-1]};
            MODE_ROR: res = {d[0], d[WIDTH-1:1]};
            MODE_SER: res = SERIAL_EN ? {d[WIDTH-2:0], sin} : d;
            default:  res = d;
        endcase
        return res;
    endfunction

    // Classify the incoming command: does it take one or more shift steps?
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_cmd_is_shift = 1'b0;
        case (shift_direction)
            MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR: w_cmd_is_shift = 1'b1;
            MODE_SER:                                         w_cmd_is_shift = SERIAL_EN;
            default:                                          w_cmd_is_shift = 1'b0;
        endcase
    end

    // First step uses the live command mode; later steps use the captured mode.
    assign w_step_cmd = f_step(shift_direction, r_data, w_serial_bit);
    assign w_step_run = f_step(r_mode, r_data, w_serial_bit);

    // FSM, data register, step counter and done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_mode  <= MODE_HOLD;
            r_count <= CNT_ZERO;
            r_done  <= 1'b0;
        end else if (!enable) begin
            // Frozen: only the done pulse is cleared.
            r_done <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (w_cmd_is_shift && (shift_amount != CNT_ZERO)) begin
                            r_data <= w_step_cmd;
                            r_mode <= shift_direction;
                            if (shift_amount == CNT_ONE) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= S_SHIFT;
                                r_count <= shift_amount - CNT_ONE;
                            end
                        end else begin
                            if (shift_direction == MODE_LOAD) begin
                                r_data <= data_in;
                            end
                            r_done <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_step_run;
                    r_count <= r_count - CNT_ONE;
                    if (r_count == CNT_ONE) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = r_data;
    assign busy     = (r_state == S_SHIFT);
    assign done     = r_done;

endmodule

// File: tb/tb_shift_reg_mc.sv
// Directed, table-driven bench for shift_reg_mc (WIDTH=8, SHIFT_W=4),
// plus hand-written sequences for start-while-busy, enable stalls and
// reset mid-operation.
module tb_shift_reg_mc;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       start;
    logic [2:0] shift_direction;
    logic [3:0] shift_amount;
    logic [7:0] data_in;
    logic       serial_in;
    logic       serial_out;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    shift_reg_mc #(.WIDTH(8), .SHIFT_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .start           (start),
        .shift_direction (shift_direction),
        .shift_amount    (shift_amount),
        .data_in         (data_in),
`ifdef SHIFT_REG_SERIAL_EN
        .serial_in       (serial_in),
        .serial_out      (serial_out),
`endif
        .data_out        (data_out),
        .busy            (busy),
        .done            (done)
    );

`ifndef SHIFT_REG_SERIAL_EN
    assign serial_out = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] init;
        logic [2:0] dir;
        logic [3:0] amt;
        logic [7:0] din;
        logic [7:0] exp_data;
        int         exp_busy;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one command at a negedge; return after the sample that follows the
    // last busy cycle (where done should be high).
    task automatic run_cmd(input logic [2:0] dir, input logic [3:0] amt, input logic [7:0] din,
                           output int busy_cycles, output logic done_seen, output int overlap);
        start           = 1'b1;
        shift_direction = dir;
        shift_amount    = amt;
        data_in         = din;
        @(negedge clk);
        start           = 1'b0;
        shift_direction = 3'b000;
        shift_amount    = 4'd0;
        data_in         = 8'h00;
        busy_cycles = 0;
        overlap     = 0;
        while (busy && busy_cycles < 40) begin
            if (done) overlap++;
            busy_cycles++;
            @(negedge clk);
        end
        done_seen = done;
    endtask

    task automatic load_value(input logic [7:0] v);
        int bc;
        logic ds;
        int ov;
        run_cmd(3'b001, 4'd0, v, bc, ds, ov);
        @(negedge clk);
    endtask

    initial begin
        int   bc;
        logic ds;
        int   ov;
        int   edges;

        vecs[0]  = '{8'h00, 3'b001, 4'd7,  8'hA5, 8'hA5, 0};
        vecs[1]  = '{8'hA5, 3'b010, 4'd3,  8'hFF, 8'h28, 2};
        vecs[2]  = '{8'h96, 3'b100, 4'd2,  8'hFF, 8'hE5, 1};
        vecs[3]  = '{8'h81, 3'b110, 4'd9,  8'hFF, 8'hC0, 8};
        vecs[4]  = '{8'h3C, 3'b011, 4'd0,  8'hFF, 8'h3C, 0};
        vecs[5]  = '{8'h5A, 3'b000, 4'd5,  8'hFF, 8'h5A, 0};
        vecs[6]  = '{8'h81, 3'b101, 4'd3,  8'hFF, 8'h0C, 2};
        vecs[7]  = '{8'hFF, 3'b011, 4'd15, 8'hFF, 8'h00, 14};
        vecs[8]  = '{8'h7F, 3'b100, 4'd1,  8'hFF, 8'h3F, 0};
`ifdef SHIFT_REG_SERIAL_EN
        vecs[9]  = '{8'h00, 3'b111, 4'd4,  8'hFF, 8'h0F, 3};
`else
        vecs[9]  = '{8'h00, 3'b111, 4'd4,  8'hFF, 8'h00, 0};
`endif
        vecs[10] = '{8'hC3, 3'b101, 4'd8,  8'hFF, 8'hC3, 7};
        vecs[11] = '{8'h01, 3'b010, 4'd1,  8'hFF, 8'h02, 0};

        reset           = 1'b0;
        enable          = 1'b1;
        start           = 1'b0;
        shift_direction = 3'b000;
        shift_amount    = 4'd0;
        data_in         = 8'h00;
        serial_in       = 1'b1;

        #1;
        check("reset_data", {24'd0, data_out}, 32'h00);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Table-driven commands.
        for (int i = 0; i < 12; i++) begin
            load_value(vecs[i].init);
            run_cmd(vecs[i].dir, vecs[i].amt, vecs[i].din, bc, ds, ov);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_busy);
            check($sformatf("v%0d_done", i), {31'd0, ds}, 32'd1);
            check($sformatf("v%0d_data", i), {24'd0, data_out}, {24'd0, vecs[i].exp_data});
            check($sformatf("v%0d_overlap", i), ov, 0);
`ifdef SHIFT_REG_SERIAL_EN
            check($sformatf("v%0d_serial_out", i), {31'd0, serial_out}, {31'd0, vecs[i].exp_data[7]});
`endif
            @(negedge clk);
            check($sformatf("v%0d_done_clear", i), {31'd0, done}, 32'd0);
        end

        // Start while busy is ignored: SLL 3 from 0xA5 with a load attempt mid-op.
        load_value(8'hA5);
        start = 1'b1; shift_direction = 3'b010; shift_amount = 4'd3;
        @(negedge clk);
        start = 1'b1; shift_direction = 3'b001; shift_amount = 4'd0; data_in = 8'hFF;
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0; shift_direction = 3'b000;
        check("busy_start_data", {24'd0, data_out}, 32'h94);
        @(negedge clk);
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_final", {24'd0, data_out}, 32'h28);
        @(negedge clk);
        check("busy_start_no_redo", {24'd0, data_out}, 32'h28);
        check("busy_start_done_clr", {31'd0, done}, 32'd0);

        // Enable low for two cycles mid-op: SLL 5 from 0xFF takes 7 edges.
        load_value(8'hFF);
        start = 1'b1; shift_direction = 3'b010; shift_amount = 4'd5;
        @(negedge clk);
        start = 1'b0; shift_direction = 3'b000; shift_amount = 4'd0;
        edges = 1;
        while (!done && edges < 30) begin
            if (edges == 2) enable = 1'b0;
            if (edges == 4) begin
                check("stall_frozen_data", {24'd0, data_out}, 32'hFC);
                check("stall_frozen_busy", {31'd0, busy}, 32'd1);
                enable = 1'b1;
            end
            @(negedge clk);
            edges++;
        end
        check("stall_edges", edges, 7);
        check("stall_data", {24'd0, data_out}, 32'hE0);
        @(negedge clk);

        // Reset asserted after step 3 of SLL 5: abort, no done pulse.
        load_value(8'hFF);
        start = 1'b1; shift_direction = 3'b010; shift_amount = 4'd5;
        @(negedge clk);
        start = 1'b0; shift_direction = 3'b000; shift_amount = 4'd0;
        repeat (2) @(negedge clk);
        check("abort_pre_data", {24'd0, data_out}, 32'hF8);
        reset = 1'b0;
        #1;
        check("abort_data", {24'd0, data_out}, 32'h00);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_done", {31'd0, done}, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        run_cmd(3'b001, 4'd0, 8'h12, bc, ds, ov);
        check("post_reset_load", {24'd0, data_out}, 32'h12);
        check("post_reset_done", {31'd0, ds}, 32'd1);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_mc.md
SHIFT_REG_MC -- requirements
Module: shift_reg_mc

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be at least 2.
REQ-002 Parameter SHIFT_W, default 4, width of shift_amount.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  global step enable; low freezes register, counter and FSM.
REQ-006 start  input  1  command strobe; sampled only when enable=1 and busy=0.
REQ-007 shift_direction  input  3  mode: 000 hold, 001 parallel load, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 serial shift-left.
REQ-008 shift_amount  input  SHIFT_W  number of one-bit steps (0..2^SHIFT_W-1).
REQ-009 data_in  input  WIDTH  parallel load value.
REQ-010 serial_in  input  1  fill bit for mode 111 (present only with SHIFT_REG_SERIAL_EN).
REQ-011 data_out  output  WIDTH  register contents.
REQ-012 serial_out  output  1  equals data_out[WIDTH-1] (present only with SHIFT_REG_SERIAL_EN).
REQ-013 busy  output  1  high while steps of an accepted command remain.
REQ-014 done  output  1  one-cycle pulse after a command's final update.

Function
REQ-015 FSM states SHALL be IDLE and SHIFT; busy=1 exactly in SHIFT.
REQ-016 A command SHALL be accepted on an edge where start=1, enable=1, busy=0; start at any other time SHALL be ignored.
REQ-017 Hold (000) SHALL leave data_out unchanged; load (001) SHALL set data_out=data_in on the accepting edge; both SHALL set done=1 for the following cycle, ignoring shift_amount.
REQ-018 Shift modes with amount N>=1 SHALL perform step 1 on the accepting edge and one step per enabled edge, N steps total on edges k..k+N-1.
REQ-019 After the accepting edge, if N>1 the FSM SHALL enter SHIFT with N-1 steps remaining; it SHALL return to IDLE on the edge performing the last step.
REQ-020 done SHALL be 1 for exactly the cycle after the final step edge; busy and done SHALL never both be 1.
REQ-021 Shift with N=0 SHALL leave data_out unchanged and pulse done after the accepting edge.
REQ-022 Step definitions: SLL {d[W-2:0],0}; SRL {0,d[W-1:1]}; SRA {d[W-1],d[W-1:1]}; ROL {d[W-2:0],d[W-1]}; ROR {d[0],d[W-1:1]}; 111 {d[W-2:0],serial_in}.
REQ-023 N>=WIDTH SHALL be legal; results follow from repeated steps (rotates wrap modulo WIDTH, logical shifts reach 0).
REQ-024 Mode and amount SHALL be captured at acceptance; input changes during SHIFT SHALL have no effect.
REQ-025 On an edge with enable=0: no step, no counter change, no acceptance, done cleared to 0; the operation resumes when enable returns.
REQ-026 done SHALL be 0 on every edge not completing a command.

Reset
REQ-027 reset=0 SHALL immediately force data_out=0, busy=0, done=0, state IDLE, step counter 0.
REQ-028 Reset mid-operation SHALL abort the command with no done pulse; the first command after release SHALL be accepted normally.

Configuration
REQ-029 Macro SHIFT_REG_SERIAL_EN defined: serial_in and serial_out ports exist and mode 111 is implemented per REQ-022.
REQ-030 Macro undefined: those ports are absent; mode 111 SHALL behave as hold (data unchanged, done pulse after the accepting edge).

Verification (WIDTH=8, SHIFT_W=4)
REQ-031 Reset, then load 0xA5 -> data_out=0xA5 after 1 edge, done high 1 cycle, busy never high.
REQ-032 From 0xA5: SLL N=3 -> busy 2 cycles, data_out=0x28, then done 1 cycle; a start during busy is ignored.
REQ-033 From 0x96: SRA N=2 -> 0xE5; from 0x81: ROR N=9 -> 0xC0 after 9 step edges.
REQ-034 From 0xFF: SLL N=5 with enable low 2 cycles mid-op -> 7 edges total, data_out=0xE0; repeat, asserting reset at step 3 -> data_out=0x00, busy=0, no done.
REQ-035 From 0x00: mode 111 N=4 with serial_in=1 -> 0x0F with macro (serial_out=0), unchanged 0x00 plus a done pulse without it.
REQ-036 SRL N=0 on 0x3C -> data_out=0x3C, done after 1 edge.
